// File: rtl/fetch_pkg.sv
// fetch_pkg: shared constants, FSM state and IF/ID record for the fetch stage
package fetch_pkg;
  localparam int PC_W = 64;
  localparam int INSTR_W = 32;
  localparam logic [INSTR_W-1:0] HALT_WORD = 32'hb400001f;
  localparam logic [INSTR_W-1:0] NOP_WORD = 32'h0;
  localparam logic [PC_W-1:0] PC_STEP = 64'd4;
  typedef enum logic {FETCH, HALTED} fetch_state_t;
  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [PC_W-1:0] pc;
    logic valid;
  } ifid_t;
endpackage

// File: rtl/fetch_stage_pc_reg.sv
// pc_reg: N-bit register with sync reset, enable and step/load select
module pc_reg #(
  parameter int N = 64
) (
  input logic clk,
  input logic reset,
  input logic en,
  input logic sel,
  input logic [N-1:0] d_step,
  input logic [N-1:0] d_load,
  output logic [N-1:0] q
);
  always_ff @(posedge clk)
    if (reset) q <= '0;
    else if (en) q <= sel ? d_load : d_step;
endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: PC, ROM addressing, IF/ID register with stall/flush, halt detect and fetch counter
module fetch_stage
  import fetch_pkg::*;
#(
  parameter int N = PC_W,
  parameter int IW = INSTR_W,
  parameter int AW = 6,
  parameter logic [IW-1:0] HALT_WORD = fetch_pkg::HALT_WORD
) (
  input logic clk,
  input logic reset,
  output logic [AW-1:0] imem_addr,
  input logic [IW-1:0] imem_q,
  input logic pcsrc,
  input logic [N-1:0] pc_branch,
  input logic stall_F,
  input logic flush_D,
  output logic [N-1:0] pc_F,
  output logic [IW-1:0] instr_D,
  output logic [N-1:0] pc_D,
  output logic valid_D,
  output logic halted,
  output logic [31:0] fetch_count
);
  fetch_state_t r_state, w_state_nxt;
  ifid_t r_ifid, w_ifid_nxt;
  logic [31:0] r_count;
  logic w_fetch, w_load;
  assign w_fetch = r_state == FETCH;
  assign w_load = w_fetch & ~flush_D & ~pcsrc & ~stall_F;
  pc_reg #(.N(N)) u_pc (
    .clk(clk),
    .reset(reset),
    .en(w_fetch & (pcsrc | ~stall_F)),
    .sel(pcsrc),
    .d_step(pc_F + N'(PC_STEP)),
    .d_load(pc_branch),
    .q(pc_F)
  );
  always_comb begin
    w_state_nxt = (w_load && imem_q == HALT_WORD) ? HALTED : r_state;
    w_ifid_nxt = (!w_fetch || flush_D || pcsrc) ? ifid_t'{instr: NOP_WORD, pc: '0, valid: 1'b0} :
                 stall_F ? r_ifid : ifid_t'{instr: imem_q, pc: pc_F, valid: 1'b1};
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= FETCH;
      r_ifid <= '0;
      r_count <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_ifid <= w_ifid_nxt;
      if (w_load && r_count != '1) r_count <= r_count + 32'd1;
    end
  end
  assign imem_addr = pc_F[AW+1:2];
  assign instr_D = r_ifid.instr;
  assign pc_D = r_ifid.pc;
  assign valid_D = r_ifid.valid;
  assign halted = r_state == HALTED;
  assign fetch_count = r_count;
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: table-driven scoreboard bench for fetch_stage
module tb_fetch_stage;
  logic clk = 1'b0;
  logic reset, pcsrc, stall_F, flush_D;
  logic [63:0] pc_branch, pc_F, pc_D;
  logic [5:0] imem_addr;
  logic [31:0] imem_q, instr_D, fetch_count;
  logic valid_D, halted;
  logic [31:0] rom [64];
  int n_vec = 0;
  int n_err = 0;
  always #5 clk = ~clk;
  assign imem_q = rom[imem_addr];
  fetch_stage dut (
    .clk(clk), .reset(reset), .imem_addr(imem_addr), .imem_q(imem_q),
    .pcsrc(pcsrc), .pc_branch(pc_branch), .stall_F(stall_F), .flush_D(flush_D),
    .pc_F(pc_F), .instr_D(instr_D), .pc_D(pc_D), .valid_D(valid_D),
    .halted(halted), .fetch_count(fetch_count)
  );
  typedef struct {
    logic rst, br, st, fl;
    logic [63:0] pcb, pc, pcd;
    logic [31:0] ins, cnt;
    logic vld, hlt;
  } vec_t;
  vec_t tbl[$];
  vec_t exp_q[$];
  function automatic vec_t mk(input logic rst, br, st, fl, input logic [63:0] pcb, pc,
                              input logic [31:0] ins, input logic [63:0] pcd,
                              input logic vld, hlt, input logic [31:0] cnt);
    vec_t v;
    v.rst = rst; v.br = br; v.st = st; v.fl = fl; v.pcb = pcb; v.pc = pc;
    v.ins = ins; v.pcd = pcd; v.vld = vld; v.hlt = hlt; v.cnt = cnt;
    return v;
  endfunction
  task automatic chk(input string nm, input int row, input logic [63:0] act, exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s row %0d: got %h expected %h", nm, row, act, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask
  initial begin
    vec_t e;
    logic [63:0] pce;
    for (int i = 0; i < 64; i++) rom[i] = 32'h91000000 + i;
    rom[0] = 32'hf8000001;
    rom[1] = 32'hf8008002;
    rom[2] = 32'hf8000203;
    rom[46] = 32'hb400001f;
    reset = 1'b1; pcsrc = 1'b0; stall_F = 1'b0; flush_D = 1'b0; pc_branch = '0;
    //        rst br st fl  pcb      pc       instr         pcD      v  h  cnt
    tbl.push_back(mk(1, 0, 0, 0, 64'h0,   64'h0,   32'h0,        64'h0,   0, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 64'h0,   64'h0,   32'h0,        64'h0,   0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 64'h0,   64'h4,   32'hf8000001, 64'h0,   1, 0, 1));
    tbl.push_back(mk(0, 0, 0, 0, 64'h0,   64'h8,   32'hf8008002, 64'h4,   1, 0, 2));
    tbl.push_back(mk(0, 0, 1, 0, 64'h0,   64'h8,   32'hf8008002, 64'h4,   1, 0, 2));
    tbl.push_back(mk(0, 0, 1, 0, 64'h0,   64'h8,   32'hf8008002, 64'h4,   1, 0, 2));
    tbl.push_back(mk(0, 0, 0, 0, 64'h0,   64'hc,   32'hf8000203, 64'h8,   1, 0, 3));
    tbl.push_back(mk(0, 0, 0, 0, 64'h0,   64'h10,  32'h91000003, 64'hc,   1, 0, 4));
    tbl.push_back(mk(0, 1, 1, 0, 64'h4,   64'h4,   32'h0,        64'h0,   0, 0, 4));
    tbl.push_back(mk(0, 0, 0, 0, 64'h0,   64'h8,   32'hf8008002, 64'h4,   1, 0, 5));
    tbl.push_back(mk(0, 0, 0, 1, 64'h0,   64'hc,   32'h0,        64'h0,   0, 0, 5));
    tbl.push_back(mk(0, 0, 1, 1, 64'h0,   64'hc,   32'h0,        64'h0,   0, 0, 5));
    tbl.push_back(mk(0, 0, 0, 0, 64'h0,   64'h10,  32'h91000003, 64'hc,   1, 0, 6));
    tbl.push_back(mk(0, 1, 0, 0, 64'hfc,  64'hfc,  32'h0,        64'h0,   0, 0, 6));
    tbl.push_back(mk(0, 0, 0, 0, 64'h0,   64'h100, 32'h9100003f, 64'hfc,  1, 0, 7));
    tbl.push_back(mk(0, 0, 0, 0, 64'h0,   64'h104, 32'hf8000001, 64'h100, 1, 0, 8));
    tbl.push_back(mk(0, 1, 0, 0, 64'h105, 64'h105, 32'h0,        64'h0,   0, 0, 8));
    tbl.push_back(mk(0, 0, 0, 0, 64'h0,   64'h109, 32'hf8008002, 64'h105, 1, 0, 9));
    tbl.push_back(mk(0, 1, 0, 0, 64'hb4,  64'hb4,  32'h0,        64'h0,   0, 0, 9));
    tbl.push_back(mk(0, 0, 0, 0, 64'h0,   64'hb8,  32'h9100002d, 64'hb4,  1, 0, 10));
    tbl.push_back(mk(0, 0, 0, 0, 64'h0,   64'hbc,  32'hb400001f, 64'hb8,  1, 1, 11));
    tbl.push_back(mk(0, 1, 0, 0, 64'h0,   64'hbc,  32'h0,        64'h0,   0, 1, 11));
    tbl.push_back(mk(0, 0, 1, 0, 64'h0,   64'hbc,  32'h0,        64'h0,   0, 1, 11));
    tbl.push_back(mk(0, 0, 0, 0, 64'h0,   64'hbc,  32'h0,        64'h0,   0, 1, 11));
    tbl.push_back(mk(1, 1, 0, 0, 64'h40,  64'h0,   32'h0,        64'h0,   0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 64'h0,   64'h4,   32'hf8000001, 64'h0,   1, 0, 1));
    tbl.push_back(mk(0, 0, 0, 0, 64'h0,   64'h8,   32'hf8008002, 64'h4,   1, 0, 2));
    tbl.push_back(mk(0, 0, 1, 0, 64'h0,   64'h8,   32'hf8008002, 64'h4,   1, 0, 2));
    tbl.push_back(mk(1, 0, 1, 0, 64'h0,   64'h0,   32'h0,        64'h0,   0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 64'h0,   64'h4,   32'hf8000001, 64'h0,   1, 0, 1));
    foreach (tbl[i]) begin
      reset = tbl[i].rst; pcsrc = tbl[i].br; stall_F = tbl[i].st;
      flush_D = tbl[i].fl; pc_branch = tbl[i].pcb;
      exp_q.push_back(tbl[i]);
      step();
      e = exp_q.pop_front();
      pce = e.pc >> 2;
      chk("pc_F", i, pc_F, e.pc);
      chk("imem_addr", i, 64'(imem_addr), 64'(pce[5:0]));
      chk("instr_D", i, 64'(instr_D), 64'(e.ins));
      chk("pc_D", i, pc_D, e.pcd);
      chk("valid_D", i, 64'(valid_D), 64'(e.vld));
      chk("halted", i, 64'(halted), 64'(e.hlt));
      chk("fetch_count", i, 64'(fetch_count), 64'(e.cnt));
    end
    reset = 1'b1; pcsrc = 1'b0; stall_F = 1'b0; flush_D = 1'b0; pc_branch = '0;
    step();
    reset = 1'b0;
    for (int k = 0; k < 100 && !halted; k++) step();
    chk("halt_reached", 100, 64'(halted), 64'd1);
    chk("halt_pc_D", 100, pc_D, 64'hb8);
    chk("halt_instr", 100, 64'(instr_D), 64'hb400001f);
    chk("halt_count", 100, 64'(fetch_count), 64'd47);
    pcsrc = 1'b1; pc_branch = 64'h20;
    step();
    pcsrc = 1'b0;
    chk("halt_pc_frozen", 101, pc_F, 64'hbc);
    chk("halt_bubble", 101, 64'(valid_D), 64'd0);
    chk("halt_count_hold", 101, 64'(fetch_count), 64'd47);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
Instruction-fetch stage of the pipelined LEGv8 core, directly upstream of the 64-word instruction ROM (imem).
- Owns the PC register and drives the ROM word address.
- Captures the ROM output into the IF/ID pipeline register, with stall and flush control.
- Detects the program-end idiom (CBZ XZR,#0 = 32'hb400001f) and freezes fetch.
- Keeps a fetched-instruction counter for bench and debug.

Parameters:
N, 64, PC / branch-target width in bits
IW, 32, instruction width (must match imem N)
AW, 6, ROM word-address width (64 words)
HALT_WORD, 32'hb400001f, encoding that ends the program

Ports:
clk  in  1  single clock; all state updates on the rising edge
reset  in  1  synchronous, active-high; sampled on the rising edge of clk
imem_addr  out  AW  ROM word index = pc_F[AW+1:2]; combinational from the PC register
imem_q  in  IW  ROM data for imem_addr (combinational ROM, same cycle)
pcsrc  in  1  branch taken (resolved downstream)
pc_branch  in  N  branch target, used when pcsrc=1
stall_F  in  1  hold PC and IF/ID (load-use hazard)
flush_D  in  1  squash the IF/ID contents
pc_F  out  N  current PC
instr_D  out  IW  IF/ID instruction
pc_D  out  N  IF/ID PC of instr_D
valid_D  out  1  instr_D is a real instruction (0 = bubble)
halted  out  1  fetch frozen after HALT_WORD was issued
fetch_count  out  32  number of valid instructions loaded into IF/ID, saturating

Behaviour:
- Reset (synchronous, active-high, overrides all other inputs): pc_F=0, instr_D=0, pc_D=0, valid_D=0, halted=0, fetch_count=0, state=FETCH.
- ROM timing: imem_addr=pc_F[7:2] with zero latency. The ROM word at PC appears in instr_D one edge later.
- FSM states:
  - FETCH: normal operation.
  - HALTED: entered on the edge at which imem_q==HALT_WORD is loaded into IF/ID with valid. Left only by reset.
- Next PC in FETCH, highest priority first:
  1. pcsrc=1 -> pc_branch (wins over stall_F).
  2. stall_F=1 -> hold.
  3. Otherwise pc_F+4, modulo 2^N.
- imem_addr wraps naturally: PC 0x100 reads word 0. pc_branch[1:0] is loaded as-is and ignored for addressing.
- IF/ID in FETCH, highest priority first:
  1. flush_D=1 or pcsrc=1 -> instr_D=0, valid_D=0, pc_D=0.
  2. stall_F=1 -> hold all three.
  3. Otherwise instr_D=imem_q, pc_D=pc_F, valid_D=1.
- Simultaneous flush_D and stall_F: flush wins; the bubble is inserted and the PC holds.
- Halt detection applies only when the load is a real load, i.e. case 3 above. It does not apply on stall, flush or branch.
- HALTED:
  - pc_F frozen; pcsrc and stall_F ignored.
  - On the first HALTED edge, IF/ID loads a bubble (valid_D=0). It keeps loading bubbles until reset.
  - halted=1 from the edge that entered HALTED.
- fetch_count increments by 1 on every edge where valid_D is loaded with 1. It stops at 32'hffffffff.
- Reset mid-operation (including during a stall or in HALTED) returns everything to the reset values on that edge.

Decomposition:
- Package fetch_pkg holds:
  - Constants: HALT_WORD, NOP_WORD (32'h0), PC_STEP (4).
  - typedef enum logic {FETCH, HALTED} fetch_state_t.
  - Packed struct ifid_t {instr, pc, valid}.
- One sub-module: pc_reg, a parameterised N-bit register with synchronous reset, enable and load-value mux, instantiated once for the PC.
- The IF/ID register stays inline.

Test Plan:
1. Linear fetch: reset 2 cycles, ROM loaded with the standard program; release reset with no stalls.
   -> imem_addr 0,1,2 on successive cycles; after edge 1 instr_D=f8000001, pc_D=0, valid_D=1; after edge 2 instr_D=f8008002, pc_D=4; fetch_count=2.
2. Stall: at pc_F=0x8 assert stall_F for 2 cycles.
   -> pc_F stays 0x8 and instr_D stays f8008002 through both cycles; on the next edge instr_D=f8000203; fetch_count does not advance while stalled.
3. Branch with stall: at pc_F=0x10 assert pcsrc=1, pc_branch=0x4, stall_F=1 for one cycle.
   -> pc_F=0x4 and valid_D=0 after the edge; on the next edge instr_D=f8008002, pc_D=0x4.
4. Flush and wrap:
   - flush_D alone -> instr_D=0, valid_D=0, PC advances by 4.
   - Branch to 0xFC -> imem_addr=63; the next PC 0x100 gives imem_addr=0.
5. Halt: run to ROM word 46 (b400001f at PC 0xB8).
   -> the edge loading it sets halted=1 and pc_D=0xB8; pc_F frozen; the following edges give valid_D=0; pcsrc pulses are ignored.
6. Reset while HALTED or mid-stall:
   -> on the next edge pc_F=0, halted=0, valid_D=0, fetch_count=0; fetch resumes from word 0.
